// File: rtl/piso_shift_param.sv
// piso_shift_param: DATA_WIDTH-bit parallel-in serial-out shifter.
// Optional trailing even-parity bit: define PISO_PARITY_EN.
module piso_shift_param #(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 1
) (
  input  logic                              Clk_In,
  input  logic                              Reset_In,
  input  logic                              Load_Valid_In,
  output logic                              Load_Ready_Out,
  input  logic [DATA_WIDTH-1:0]             Parallel_Data_In,
  input  logic                              Shift_Enable_In,
  output logic                              Serial_Data_Out,
  output logic                              Serial_Valid_Out,
  output logic                              Busy_Out,
  output logic                              Frame_Done_Out,
  output logic [$clog2(DATA_WIDTH+2)-1:0]   Bit_Count_Out
);

  localparam int   CW   = $clog2(DATA_WIDTH + 2);
  localparam logic FILL = (IDLE_LEVEL != 0);
  localparam logic LSBF = (LSB_FIRST != 0);

`ifdef PISO_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
  localparam int LAST_DATA  = 2;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
  localparam int LAST_DATA  = 1;
`endif

  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_DATA);
  localparam logic [DATA_WIDTH-1:0] SREG_IDLE = {DATA_WIDTH{FILL}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  sout_q, sout_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
`ifdef PISO_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic [DATA_WIDTH-1:0] sh_lsb;
  logic [DATA_WIDTH-1:0] sh_msb;
  logic                  nxt_lsb;
  logic                  nxt_msb;
  logic                  first_bit;

  // Both shift directions; the parameter picks one.
  assign sh_lsb    = {FILL, sreg_q[DATA_WIDTH-1:1]};
  assign sh_msb    = {sreg_q[DATA_WIDTH-2:0], FILL};
  assign nxt_lsb   = sreg_q[1];
  assign nxt_msb   = sreg_q[DATA_WIDTH-2];
  assign first_bit = LSBF ? Parallel_Data_In[0]
                          : Parallel_Data_In[DATA_WIDTH-1];

  // State and datapath registers.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= S_IDLE;
      sreg_q  <= SREG_IDLE;
      sout_q  <= FILL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (Load_Valid_In) begin
          state_d = S_SHIFT;
          sreg_d  = Parallel_Data_In;
          sout_d  = first_bit;
          cnt_d   = CNT_LOAD;
`ifdef PISO_PARITY_EN
          par_d   = ^Parallel_Data_In;
`endif
        end
      end
      S_SHIFT: begin
        if (Shift_Enable_In) begin
          unique case (1'b1)
            (cnt_q == CNT_LAST): begin
              sreg_d = SREG_IDLE;
`ifdef PISO_PARITY_EN
              state_d = S_PARITY;
              sout_d  = par_q;
              cnt_d   = CW'(1);
`else
              state_d = S_IDLE;
              sout_d  = FILL;
              cnt_d   = '0;
              done_d  = 1'b1;
`endif
            end
            (cnt_q != CNT_LAST): begin
              sreg_d = LSBF ? sh_lsb : sh_msb;
              sout_d = LSBF ? nxt_lsb : nxt_msb;
              cnt_d  = cnt_q - CW'(1);
            end
          endcase
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (Shift_Enable_In) begin
          state_d = S_IDLE;
          sout_d  = FILL;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        sreg_d  = SREG_IDLE;
        sout_d  = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    Load_Ready_Out   = (state_q == S_IDLE);
    Busy_Out         = (state_q != S_IDLE);
    Serial_Valid_Out = (state_q != S_IDLE);
    Serial_Data_Out  = sout_q;
    Frame_Done_Out   = done_q;
    Bit_Count_Out    = cnt_q;
  end

endmodule

// File: tb/tb_piso_shift_param.sv
// tb_piso_shift_param: scoreboard bench for piso_shift_param.
// Covers 8-bit LSB/MSB, 2-bit idle-low and 32-bit MSB builds.
module tb_piso_shift_param;

`ifdef PISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB8 = 8 + PB;

  logic clk;
  logic rst;

  logic       a_vld, a_en;
  logic [7:0] a_dat;
  logic       al_rdy, al_sd, al_sv, al_busy, al_fd;
  logic [3:0] al_cnt;
  logic       am_rdy, am_sd, am_sv, am_busy, am_fd;
  logic [3:0] am_cnt;

  logic       b_vld, b_en;
  logic [1:0] b_dat;
  logic       b_rdy, b_sd, b_sv, b_busy, b_fd;
  logic [1:0] b_cnt;

  logic        c_vld, c_en;
  logic [31:0] c_dat;
  logic        c_rdy, c_sd, c_sv, c_busy, c_fd;
  logic [5:0]  c_cnt;

  bit qal[$];
  bit qam[$];
  bit qb[$];
  bit qc[$];

  int nchk, nerr;
  int al_done, am_done, b_done, c_done;
  int a_frames, b_frames, c_frames;

  piso_shift_param #(.DATA_WIDTH(8), .LSB_FIRST(1), .IDLE_LEVEL(1)) u_al (
    .Clk_In(clk), .Reset_In(rst),
    .Load_Valid_In(a_vld), .Load_Ready_Out(al_rdy),
    .Parallel_Data_In(a_dat), .Shift_Enable_In(a_en),
    .Serial_Data_Out(al_sd), .Serial_Valid_Out(al_sv),
    .Busy_Out(al_busy), .Frame_Done_Out(al_fd),
    .Bit_Count_Out(al_cnt)
  );

  piso_shift_param #(.DATA_WIDTH(8), .LSB_FIRST(0), .IDLE_LEVEL(1)) u_am (
    .Clk_In(clk), .Reset_In(rst),
    .Load_Valid_In(a_vld), .Load_Ready_Out(am_rdy),
    .Parallel_Data_In(a_dat), .Shift_Enable_In(a_en),
    .Serial_Data_Out(am_sd), .Serial_Valid_Out(am_sv),
    .Busy_Out(am_busy), .Frame_Done_Out(am_fd),
    .Bit_Count_Out(am_cnt)
  );

  piso_shift_param #(.DATA_WIDTH(2), .LSB_FIRST(1), .IDLE_LEVEL(0)) u_b (
    .Clk_In(clk), .Reset_In(rst),
    .Load_Valid_In(b_vld), .Load_Ready_Out(b_rdy),
    .Parallel_Data_In(b_dat), .Shift_Enable_In(b_en),
    .Serial_Data_Out(b_sd), .Serial_Valid_Out(b_sv),
    .Busy_Out(b_busy), .Frame_Done_Out(b_fd),
    .Bit_Count_Out(b_cnt)
  );

  piso_shift_param #(.DATA_WIDTH(32), .LSB_FIRST(0), .IDLE_LEVEL(1)) u_c (
    .Clk_In(clk), .Reset_In(rst),
    .Load_Valid_In(c_vld), .Load_Ready_Out(c_rdy),
    .Parallel_Data_In(c_dat), .Shift_Enable_In(c_en),
    .Serial_Data_Out(c_sd), .Serial_Valid_Out(c_sv),
    .Busy_Out(c_busy), .Frame_Done_Out(c_fd),
    .Bit_Count_Out(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic push_a(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      qal.push_back(w[i]);
      qam.push_back(w[7-i]);
    end
    if (PB != 0) begin
      qal.push_back(^w);
      qam.push_back(^w);
    end
    a_frames++;
  endtask

  task automatic push_b(input logic [1:0] w);
    for (int i = 0; i < 2; i++) qb.push_back(w[i]);
    if (PB != 0) qb.push_back(^w);
    b_frames++;
  endtask

  task automatic push_c(input logic [31:0] w);
    for (int i = 0; i < 32; i++) qc.push_back(w[31-i]);
    if (PB != 0) qc.push_back(^w);
    c_frames++;
  endtask

  // Scoreboard: a line bit is consumed on an edge with strobe and valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_en && al_sv) begin
        if (qal.size() == 0) chk("al_extra", 1, 0);
        else chk("al_bit", al_sd, qal.pop_front());
      end
      if (a_en && am_sv) begin
        if (qam.size() == 0) chk("am_extra", 1, 0);
        else chk("am_bit", am_sd, qam.pop_front());
      end
      if (b_en && b_sv) begin
        if (qb.size() == 0) chk("b_extra", 1, 0);
        else chk("b_bit", b_sd, qb.pop_front());
      end
      if (c_en && c_sv) begin
        if (qc.size() == 0) chk("c_extra", 1, 0);
        else chk("c_bit", c_sd, qc.pop_front());
      end
      if (al_fd) al_done++;
      if (am_fd) am_done++;
      if (b_fd) b_done++;
      if (c_fd) c_done++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ord_l;
    logic [7:0]  ord_m;
    logic [7:0]  sw;
    logic [1:0]  bw;
    logic [31:0] cw;
    int          busy_n;
    int          idx;
    bit          got;

    nchk = 0; nerr = 0;
    al_done = 0; am_done = 0; b_done = 0; c_done = 0;
    a_frames = 0; b_frames = 0; c_frames = 0;
    rst = 1'b1;
    a_vld = 0; a_en = 0; a_dat = '0;
    b_vld = 0; b_en = 0; b_dat = '0;
    c_vld = 0; c_en = 0; c_dat = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sd", al_sd, 1);
    chk("rst_sv", al_sv, 0);
    chk("rst_busy", al_busy, 0);
    chk("rst_rdy", al_rdy, 1);
    chk("rst_fd", al_fd, 0);
    chk("rst_cnt", al_cnt, 0);
    chk("rst_b_sd", b_sd, 0);
    chk("rst_c_rdy", c_rdy, 1);
    rst = 1'b0;

    // Bit order, enable tied high, 8'h1E.
    ord_l = 8'b0001_1110;
    ord_m = 8'b0111_1000;
    @(posedge clk); #1;
    a_vld = 1; a_dat = 8'h1E; a_en = 1;
    push_a(8'h1E);
    @(posedge clk); #1;
    a_vld = 0;
    for (int i = 0; i < FB8; i++) begin
      @(negedge clk);
      chk("ord_cnt_l", al_cnt, FB8 - i);
      chk("ord_cnt_m", am_cnt, FB8 - i);
      if (i < 8) begin
        chk("ord_l", al_sd, ord_l[i]);
        chk("ord_m", am_sd, ord_m[i]);
      end
    end
    @(negedge clk);
    chk("ord_fd_l", al_fd, 1);
    chk("ord_fd_m", am_fd, 1);
    chk("ord_idle_l", al_sd, 1);
    chk("ord_idle_m", am_sd, 1);
    chk("ord_cnt0", al_cnt, 0);
    chk("ord_busy0", al_busy, 0);
    @(negedge clk);
    chk("ord_fd_end", al_fd, 0);

    // Strobe one cycle in four, 8'hA5.
    sw = 8'hA5;
    busy_n = 0;
    @(posedge clk); #1;
    a_vld = 1; a_dat = sw; a_en = 0;
    push_a(sw);
    for (int c = 1; c <= 4 * FB8 + 4; c++) begin
      @(posedge clk); #1;
      a_vld = 0;
      a_en = (c % 4 == 0);
      @(negedge clk);
      if (al_busy) busy_n++;
      if (c <= 4 * FB8) begin
        idx = (c - 1) / 4;
        if (idx < 8) chk("hold", al_sd, sw[idx]);
        else chk("hold_par", al_sd, ^sw);
      end
    end
    chk("stall_busy", busy_n, 4 * FB8);
    a_en = 1;

    // Load held during an active frame is taken in the done cycle.
    @(posedge clk); #1;
    a_vld = 1; a_dat = 8'hFF;
    push_a(8'hFF);
    @(posedge clk); #1;
    a_dat = 8'h55;
    for (int c = 1; c <= FB8; c++) begin
      @(negedge clk);
      chk("hs_rdy0", al_rdy, 0);
      chk("hs_busy", al_busy, 1);
    end
    @(negedge clk);
    chk("hs_fd", al_fd, 1);
    chk("hs_rdy1", al_rdy, 1);
    push_a(8'h55);
    @(posedge clk); #1;
    a_vld = 0;
    @(negedge clk);
    chk("hs_first_l", al_sd, 1);
    chk("hs_first_m", am_sd, 0);
    chk("hs_cnt", al_cnt, FB8);
    repeat (FB8 + 1) @(negedge clk);

    // Reset after three bits of 8'h0F.
    @(posedge clk); #1;
    a_vld = 1; a_dat = 8'h0F;
    push_a(8'h0F);
    @(posedge clk); #1;
    a_vld = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("mrst_sd", al_sd, 1);
    chk("mrst_sd_m", am_sd, 1);
    chk("mrst_busy", al_busy, 0);
    chk("mrst_cnt", al_cnt, 0);
    chk("mrst_fd", al_fd, 0);
    chk("mrst_sv", al_sv, 0);
    chk("mrst_rdy", al_rdy, 1);
    qal.delete();
    qam.delete();
    a_frames--;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    a_vld = 1; a_dat = 8'h81;
    push_a(8'h81);
    @(posedge clk); #1;
    a_vld = 0;
    repeat (FB8) @(negedge clk);
    @(negedge clk);
    chk("post_rst_fd", al_fd, 1);

    // 2-bit, idle-low, random words and strobe.
    for (int n = 0; n < 30; n++) begin
      bw = 2'($urandom);
      @(posedge clk); #1;
      b_vld = 1; b_dat = bw;
      b_en = 1'($urandom_range(0, 1));
      push_b(bw);
      @(posedge clk); #1;
      b_vld = 0;
      b_dat = 2'($urandom);
      b_en = 1'($urandom_range(0, 1));
      got = 0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (b_fd) begin
          got = 1;
          break;
        end
        @(posedge clk); #1;
        b_en = 1'($urandom_range(0, 1));
      end
      chk("b_frame_end", got, 1);
      chk("b_idle", b_sd, 0);
    end

    // 32-bit MSB-first, random words and strobe.
    for (int n = 0; n < 20; n++) begin
      cw = $urandom;
      @(posedge clk); #1;
      c_vld = 1; c_dat = cw;
      c_en = 1'($urandom_range(0, 1));
      push_c(cw);
      @(posedge clk); #1;
      c_vld = 0;
      c_dat = $urandom;
      c_en = 1'($urandom_range(0, 1));
      got = 0;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        if (c_fd) begin
          got = 1;
          break;
        end
        @(posedge clk); #1;
        c_en = 1'($urandom_range(0, 1));
      end
      chk("c_frame_end", got, 1);
      chk("c_idle", c_sd, 1);
    end

    repeat (3) @(negedge clk);
    chk("al_q_empty", 32'(qal.size()), 0);
    chk("am_q_empty", 32'(qam.size()), 0);
    chk("b_q_empty", 32'(qb.size()), 0);
    chk("c_q_empty", 32'(qc.size()), 0);
    chk("al_frames", al_done, a_frames);
    chk("am_frames", am_done, a_frames);
    chk("b_frames", b_done, b_frames);
    chk("c_frames", c_done, c_frames);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
